// File: rtl/pcap_dma_pkg.sv
// Shared types and constants for the PCAP capture-to-DDR DMA sequencer.
package pcap_dma_pkg;

  localparam int BURST_BYTES = 64;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int ST_BLOCK_DONE = 0;
  localparam int ST_CAPT_DONE  = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_AXI_ERR    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_IRQ
  } state_e;

endpackage

// File: rtl/pcap_addr_queue.sv
// Small FIFO of host buffer addresses; pushes while full are dropped.
module pcap_addr_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [31:0] data_i,
  input  logic        pop_i,
  output logic [31:0] data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pcap_dma_ctrl.sv
// Moves capture FIFO words into host buffers with AXI4 INCR bursts and
// reports buffer/capture completion, overrun and bus errors via a one-cycle IRQ.
module pcap_dma_ctrl
  import pcap_dma_pkg::*;
#(
  parameter int BURST_LEN    = BURST_BYTES / 4,
  parameter int ADDR_Q_DEPTH = 4
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        enable_i,
  input  logic        flush_i,
  input  logic [31:0] block_size_i,
  input  logic [31:0] dma_addr_i,
  input  logic        dma_addr_wstb_i,
  output logic        addr_q_full_o,
  input  logic [31:0] fifo_data_i,
  input  logic [10:0] fifo_count_i,
  output logic        fifo_rd_o,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        irq_o,
  output logic [3:0]  irq_status_o,
  output logic [31:0] irq_bytes_o,
  output logic        busy_o
);

  localparam int              LW       = $clog2(BURST_LEN) + 1;
  localparam logic [LW-1:0]   LEN_FULL = LW'(BURST_LEN);
  localparam logic [LW-1:0]   LEN_ONE  = LW'(1);

  state_e        state_q, state_d;
  logic          enable_q;
  logic          flush_pend_q, flush_pend_d;
  logic [31:0]   cur_addr_q, cur_addr_d;
  logic [31:0]   bytes_q, bytes_d, bytes_sum;
  logic [LW-1:0] len_q, len_d, beat_q, beat_d;
  logic          awvalid_q, awvalid_d;
  logic [3:0]    status_q, status_d;
  logic          q_pop, q_empty, last_beat;
  logic [31:0]   q_data;

  pcap_addr_queue #(.DEPTH(ADDR_Q_DEPTH)) u_addr_q (
    .clk_i   (ACLK),
    .rst_ni  (ARESETn),
    .push_i  (dma_addr_wstb_i),
    .data_i  (dma_addr_i),
    .pop_i   (q_pop),
    .data_o  (q_data),
    .full_o  (addr_q_full_o),
    .empty_o (q_empty)
  );

  assign last_beat = (beat_q == (len_q - LEN_ONE));
  assign bytes_sum = bytes_q + 32'({len_q, 2'b00});

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    bytes_d    = bytes_q;
    len_d      = len_q;
    beat_d     = beat_q;
    awvalid_d  = awvalid_q;
    status_d   = status_q;
    q_pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        status_d = '0;
        if (enable_i && !enable_q) state_d = S_START;
      end
      S_START: begin
        bytes_d  = '0;
        status_d = '0;
        if (q_empty) begin
          status_d[ST_OVERRUN] = 1'b1;
          state_d = S_IRQ;
        end else begin
          q_pop      = 1'b1;
          cur_addr_d = q_data;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        beat_d = '0;
        // A pending flush drains whatever is left before enable is considered.
        if (flush_pend_q) begin
          if (fifo_count_i == '0) begin
            status_d[ST_CAPT_DONE] = 1'b1;
            state_d = S_IRQ;
          end else begin
            len_d   = (fifo_count_i >= 11'(BURST_LEN)) ? LEN_FULL : fifo_count_i[LW-1:0];
            state_d = S_ADDR;
          end
        end else if (!enable_i) begin
          status_d[ST_CAPT_DONE] = 1'b1;
          state_d = S_IRQ;
        end else if (fifo_count_i >= 11'(BURST_LEN)) begin
          len_d   = LEN_FULL;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!awvalid_q) begin
          awvalid_d = 1'b1;
        end else if (m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (m_axi_wready) begin
          if (last_beat) state_d = S_RESP;
          else           beat_d  = beat_q + LEN_ONE;
        end
      end
      S_RESP: begin
        if (m_axi_bvalid) begin
          bytes_d = bytes_sum;
          if (m_axi_bresp != AXI_RESP_OKAY) begin
            status_d[ST_AXI_ERR] = 1'b1;
            state_d = S_IRQ;
          end else if (bytes_sum == block_size_i) begin
            // Fold capture end or a missing next buffer into the same IRQ.
            status_d[ST_BLOCK_DONE] = 1'b1;
            if (flush_pend_q || flush_i)   status_d[ST_CAPT_DONE] = 1'b1;
            else if (enable_i && q_empty)  status_d[ST_OVERRUN]   = 1'b1;
            state_d = S_IRQ;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_IRQ: begin
        if ((status_q == 4'(1 << ST_BLOCK_DONE)) && enable_i) state_d = S_START;
        else                                                  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    flush_pend_d = (state_d == S_IDLE) ? 1'b0 : (flush_pend_q | flush_i);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= S_IDLE;
      enable_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      cur_addr_q   <= '0;
      bytes_q      <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      awvalid_q    <= 1'b0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_i;
      flush_pend_q <= flush_pend_d;
      cur_addr_q   <= cur_addr_d;
      bytes_q      <= bytes_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      awvalid_q    <= awvalid_d;
      status_q     <= status_d;
    end
  end

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awvalid_q ? (cur_addr_q + bytes_q) : '0;
  assign m_axi_awlen   = awvalid_q ? 8'(len_q - LEN_ONE) : '0;
  assign m_axi_wvalid  = (state_q == S_DATA);
  assign m_axi_wlast   = m_axi_wvalid & last_beat;
  assign m_axi_wdata   = m_axi_wvalid ? fifo_data_i : '0;
  assign fifo_rd_o     = m_axi_wvalid & m_axi_wready;
  assign m_axi_bready  = (state_q == S_RESP);
  assign irq_o         = (state_q == S_IRQ);
  assign irq_status_o  = irq_o ? status_q : '0;
  assign irq_bytes_o   = irq_o ? bytes_q : '0;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pcap_dma_ctrl.sv
// Directed bench: expected AW bursts and IRQs are queued per scenario and
// checked against every handshake; a FIFO/AXI slave model drives the DUT.
module tb_pcap_dma_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        enable_i, flush_i, dma_addr_wstb_i;
  logic [31:0] block_size_i, dma_addr_i;
  logic        addr_q_full_o, fifo_rd_o;
  logic [31:0] fifo_data_i;
  logic [10:0] fifo_count_i;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        irq_o, busy_o;
  logic [3:0]  irq_status_o;
  logic [31:0] irq_bytes_o;

  always #5 ACLK = ~ACLK;

  pcap_dma_ctrl dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .enable_i(enable_i), .flush_i(flush_i),
    .block_size_i(block_size_i), .dma_addr_i(dma_addr_i), .dma_addr_wstb_i(dma_addr_wstb_i),
    .addr_q_full_o(addr_q_full_o), .fifo_data_i(fifo_data_i), .fifo_count_i(fifo_count_i),
    .fifo_rd_o(fifo_rd_o), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .irq_o(irq_o), .irq_status_o(irq_status_o), .irq_bytes_o(irq_bytes_o), .busy_o(busy_o)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [3:0] st; logic [31:0] bytes; } irq_t;

  aw_t  exp_aw[$];
  irq_t exp_irq[$];
  int   burst_q[$];

  int total = 0, bad = 0;
  int n_aw = 0, n_b = 0, n_irq = 0, n_wv = 0, cyc = 0;
  int beat = 0, b_pending = 0;
  logic err_next = 1'b0, stall_w = 1'b0;
  logic [3:0]  last_st;
  logic [31:0] last_bytes;
  logic [7:0]  last_awlen;

  logic [31:0] fifo_mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_count_i = 11'(wr_ptr - rd_ptr);
  assign fifo_data_i  = fifo_mem[10'(rd_ptr)];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic miss(string name, string detail);
    total++;
    bad++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // One clock: observe at negedge, then drive slave/FIFO inputs 1ns after posedge.
  task automatic tick();
    logic aw_hs, w_hs, b_hs, w_end;
    aw_t  ea;
    irq_t ei;
    w_end = 1'b0;
    @(negedge ACLK);
    aw_hs = m_axi_awvalid & m_axi_awready;
    w_hs  = m_axi_wvalid & m_axi_wready;
    b_hs  = m_axi_bvalid & m_axi_bready;
    if (m_axi_wvalid) begin
      n_wv++;
      chk("fifo_rd", 32'(fifo_rd_o), 32'(m_axi_wready));
    end
    if (aw_hs) begin
      n_aw++;
      last_awlen = m_axi_awlen;
      if (exp_aw.size() == 0) miss("aw_unexpected", $sformatf("got addr %0h want none", m_axi_awaddr));
      else begin
        ea = exp_aw.pop_front();
        chk("awaddr", m_axi_awaddr, ea.addr);
        chk("awlen", 32'(m_axi_awlen), 32'(ea.len));
        burst_q.push_back(int'(ea.len) + 1);
      end
    end
    if (w_hs) begin
      chk("wdata", m_axi_wdata, fifo_mem[10'(rd_ptr)]);
      if (burst_q.size() == 0) miss("w_unexpected", "got beat want none");
      else begin
        w_end = (beat == burst_q[0] - 1);
        chk("wlast", 32'(m_axi_wlast), 32'(w_end));
      end
    end
    if (b_hs) n_b++;
    if (irq_o) begin
      n_irq++;
      last_st    = irq_status_o;
      last_bytes = irq_bytes_o;
      if (exp_irq.size() == 0) miss("irq_unexpected", $sformatf("got status %0h want none", irq_status_o));
      else begin
        ei = exp_irq.pop_front();
        chk("irq_status", 32'(irq_status_o), 32'(ei.st));
        chk("irq_bytes", irq_bytes_o, ei.bytes);
      end
    end
    @(posedge ACLK);
    #1;
    cyc++;
    if (w_hs) begin
      rd_ptr++;
      if (w_end) begin
        beat = 0;
        void'(burst_q.pop_front());
        b_pending++;
      end else beat++;
    end
    if (b_hs) m_axi_bvalid = 1'b0;
    else if (b_pending > 0 && !m_axi_bvalid) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = err_next ? 2'b10 : 2'b00;
      err_next     = 1'b0;
      b_pending--;
    end
    m_axi_awready = (cyc % 3) != 1;
    m_axi_wready  = stall_w ? 1'b0 : ((cyc % 4) != 2);
  endtask

  function automatic int cnt(int sel);
    case (sel)
      0: return n_aw;
      1: return n_b;
      2: return n_irq;
      default: return n_wv;
    endcase
  endfunction

  task automatic wait_for(string name, int sel, int delta);
    int target;
    target = cnt(sel) + delta;
    for (int i = 0; i < 3000 && cnt(sel) < target; i++) tick();
    if (cnt(sel) < target) miss({name, "_timeout"}, $sformatf("got count %0d want %0d", cnt(sel), target));
  endtask

  task automatic push_addr(logic [31:0] a);
    dma_addr_i      = a;
    dma_addr_wstb_i = 1'b1;
    tick();
    dma_addr_wstb_i = 1'b0;
  endtask

  task automatic fill(int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[10'(wr_ptr)] = 32'hA500_0000 + 32'(wr_ptr) * 32'h0001_0003;
      wr_ptr++;
    end
  endtask

  task automatic expect_bursts(logic [31:0] base, int n, int beats);
    for (int k = 0; k < n; k++) exp_aw.push_back('{base + 32'(k * beats * 4), 8'(beats - 1)});
  endtask

  task automatic expect_irq(logic [3:0] st, logic [31:0] bytes);
    exp_irq.push_back('{st, bytes});
  endtask

  task automatic end_test(string name);
    enable_i = 1'b0;
    for (int i = 0; i < 200 && busy_o; i++) tick();
    tick();
    chk({name, "_idle"}, 32'(busy_o), 32'd0);
    chk({name, "_aw_left"}, 32'(exp_aw.size()), 32'd0);
    chk({name, "_irq_left"}, 32'(exp_irq.size()), 32'd0);
  endtask

  initial begin
    ARESETn = 1'b0; enable_i = 1'b0; flush_i = 1'b0; dma_addr_wstb_i = 1'b0;
    block_size_i = 32'd128; dma_addr_i = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_awvalid", 32'(m_axi_awvalid), 0);
    chk("rst_wvalid", 32'(m_axi_wvalid), 0);
    chk("rst_bready", 32'(m_axi_bready), 0);
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_irq_status", 32'(irq_status_o), 0);
    chk("rst_irq_bytes", irq_bytes_o, 0);
    chk("rst_full", 32'(addr_q_full_o), 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    ARESETn = 1'b1;
    tick();

    // Two full bursts fill a 128-byte buffer; enable dropped before it completes.
    push_addr(32'h0010_0000);
    block_size_i = 32'd128;
    fill(32);
    expect_bursts(32'h0010_0000, 2, 16);
    expect_irq(4'b0001, 32'd128);
    enable_i = 1'b1;
    wait_for("t1_aw", 0, 2);
    enable_i = 1'b0;
    wait_for("t1_irq", 2, 1);
    end_test("t1");
    chk("t1_naw", 32'(n_aw), 32'd2);
    chk("t1_last_st", 32'(last_st), 32'h1);
    chk("t1_last_bytes", last_bytes, 32'd128);

    // Buffer rollover to the second address, then flush with an empty FIFO.
    push_addr(32'h0020_0000);
    push_addr(32'h0030_0000);
    fill(48);
    expect_bursts(32'h0020_0000, 2, 16);
    expect_irq(4'b0001, 32'd128);
    expect_bursts(32'h0030_0000, 1, 16);
    expect_irq(4'b0010, 32'd64);
    enable_i = 1'b1;
    wait_for("t2_b", 1, 3);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_for("t2_irq", 2, 1);
    end_test("t2");
    chk("t2_last_bytes", last_bytes, 32'd64);

    // Partial burst of 5 words on flush.
    push_addr(32'h0040_0000);
    fill(5);
    expect_bursts(32'h0040_0000, 1, 5);
    expect_irq(4'b0010, 32'd20);
    enable_i = 1'b1;
    repeat (6) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_for("t3_irq", 2, 1);
    end_test("t3");
    chk("t3_awlen", 32'(last_awlen), 32'd4);
    chk("t3_last_st", 32'(last_st), 32'h2);

    // Enable with no buffer queued.
    expect_irq(4'b0100, 32'd0);
    enable_i = 1'b1;
    wait_for("t4a_irq", 2, 1);
    end_test("t4a");

    // Buffer completes while no further address is queued.
    push_addr(32'h0050_0000);
    block_size_i = 32'd64;
    fill(16);
    expect_bursts(32'h0050_0000, 1, 16);
    expect_irq(4'b0101, 32'd64);
    enable_i = 1'b1;
    wait_for("t4b_irq", 2, 1);
    end_test("t4b");
    chk("t4b_last_st", 32'(last_st), 32'h5);

    // SLVERR on the first burst stops the capture.
    push_addr(32'h0060_0000);
    block_size_i = 32'd128;
    fill(32);
    err_next = 1'b1;
    expect_bursts(32'h0060_0000, 1, 16);
    expect_irq(4'b1000, 32'd64);
    enable_i = 1'b1;
    wait_for("t5_irq", 2, 1);
    rd_ptr = wr_ptr;
    repeat (20) tick();
    end_test("t5");

    // Fill the address queue, then reset in the middle of a stalled data phase.
    push_addr(32'h0070_0000);
    push_addr(32'h0080_0000);
    push_addr(32'h0090_0000);
    push_addr(32'h00A0_0000);
    chk("t6_full", 32'(addr_q_full_o), 32'd1);
    push_addr(32'h00B0_0000);
    fill(16);
    stall_w = 1'b1;
    m_axi_wready = 1'b0;
    expect_bursts(32'h0070_0000, 1, 16);
    enable_i = 1'b1;
    wait_for("t6_wvalid", 3, 1);
    ARESETn = 1'b0;
    #1;
    chk("t6_rst_awvalid", 32'(m_axi_awvalid), 0);
    chk("t6_rst_wvalid", 32'(m_axi_wvalid), 0);
    chk("t6_rst_bready", 32'(m_axi_bready), 0);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_full", 32'(addr_q_full_o), 0);
    enable_i = 1'b0;
    stall_w = 1'b0;
    burst_q.delete();
    exp_aw.delete();
    beat = 0;
    b_pending = 0;
    m_axi_bvalid = 1'b0;
    rd_ptr = wr_ptr;
    repeat (2) tick();
    ARESETn = 1'b1;
    tick();
    expect_irq(4'b0100, 32'd0);
    enable_i = 1'b1;
    wait_for("t6_irq", 2, 1);
    end_test("t6");
    chk("t6_last_st", 32'(last_st), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
